// File: rtl/sramlike_pkg.sv
// Shared types for the SRAM-like data bridge: FSM state encoding and
// transfer size codes.
package sramlike_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sramlike_bridge_if.sv
// Memory-side SRAM-like bus between the data bridge (master) and memory (slave).
interface d_sramlike_bridge_if;

    // req is the request-valid and addr_ok its ready: the request (wr/size/addr/wdata)
    // is accepted on a cycle with req & addr_ok, and the payload must not change until
    // then. data_ok marks the transfer completing; rdata is valid with it for reads.
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/d_sramlike_bridge_strb2size.sv
// Combinational decode of byte-write strobes into an SRAM-like transfer size.
module strb2size
    import sramlike_pkg::*;
(
    input  logic [3:0] strb,
    output logic [1:0] size
);

    always_comb begin
        size = SIZE_WORD;
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            default:                            size = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/d_sramlike_bridge.sv
// M-stage data access to SRAM-like bus bridge with pipeline stall generation.
// Optional kseg0/kseg1 address folding is enabled by defining DBRIDGE_ADDR_MAP_EN.
module d_sramlike_bridge
    import sramlike_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_sram_en,
    input  logic [3:0]                 memwriteEN,
    input  logic [31:0]                aluoutM,
    input  logic [31:0]                writedataM,
    input  logic                       hasException,
    input  logic                       longest_stall,
    output logic [31:0]                readdataM,
    output logic                       d_stall,
    d_sramlike_bridge_if.master        mem,
    output state_t                     state
);

    state_t      next_state;
    logic        start;
    logic        accept;
    logic        finish;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  strb_size;
    logic [31:0] raw_addr;
    logic [31:0] req_addr;

    strb2size u_strb2size (
        .strb (memwriteEN),
        .size (strb_size)
    );

    assign start  = (state == S_IDLE) & data_sram_en & ~hasException;
    assign accept = (state == S_ADDR) & mem.addr_ok;
    // data_ok only counts once the address phase has been accepted
    assign finish = (accept & mem.data_ok) | ((state == S_DATA) & mem.data_ok);

    // Reads always fetch the aligned word; the core picks the lane.
    assign raw_addr = (memwriteEN == 4'b0000) ? {aluoutM[31:2], 2'b00} : aluoutM;

`ifdef DBRIDGE_ADDR_MAP_EN
    assign req_addr = (raw_addr[31:30] == 2'b10) ? {3'b000, raw_addr[28:0]} : raw_addr;
`else
    assign req_addr = raw_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_ADDR;
            S_ADDR: begin
                if (accept) next_state = mem.data_ok ? S_DONE : S_DATA;
            end
            S_DATA: if (mem.data_ok) next_state = S_DONE;
            // Hold here while frozen so the same M-stage access is not issued twice
            S_DONE: if (!longest_stall) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (start) begin
            wr_q    <= |memwriteEN;
            size_q  <= strb_size;
            addr_q  <= req_addr;
            wdata_q <= writedataM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdataM <= 32'd0;
        end else if (finish && !wr_q) begin
            readdataM <= mem.rdata;
        end
    end

    assign mem.req   = (state == S_ADDR);
    assign mem.wr    = wr_q;
    assign mem.size  = size_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    assign d_stall = start | (state == S_ADDR) | (state == S_DATA);

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// Self-checking bench for d_sramlike_bridge: scripted memory latencies with a
// per-cycle timeline model, random transactions and pinned directed cases.
module tb_d_sramlike_bridge;
    import sramlike_pkg::*;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  memwriteEN;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        hasException;
    logic        longest_stall;
    logic [31:0] readdataM;
    logic        d_stall;
    state_t      state;

    d_sramlike_bridge_if mem_if ();

    d_sramlike_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .data_sram_en  (data_sram_en),
        .memwriteEN    (memwriteEN),
        .aluoutM       (aluoutM),
        .writedataM    (writedataM),
        .hasException  (hasException),
        .longest_stall (longest_stall),
        .readdataM     (readdataM),
        .d_stall       (d_stall),
        .mem           (mem_if),
        .state         (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int req_pulses = 0;
    logic prev_req = 1'b0;
    logic chk_en = 1'b0;

    // model expectations for the current cycle
    logic        exp_stall;
    logic        exp_req;
    state_t      exp_state;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_val_q;
    logic [31:0] obs_addr;
    logic [1:0]  obs_size;
    logic        obs_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_size(input logic [3:0] s);
        if (s == 4'b0000) return 2'd2;
        if (s == 4'b0001 || s == 4'b0010 || s == 4'b0100 || s == 4'b1000) return 2'd0;
        if (s == 4'b0011 || s == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_addr(input logic [3:0] s, input logic [31:0] a);
        logic [31:0] r;
        r = (s == 4'b0000) ? (a & 32'hFFFF_FFFC) : a;
`ifdef DBRIDGE_ADDR_MAP_EN
        if (r >= 32'h8000_0000 && r <= 32'hBFFF_FFFF) r = r & 32'h1FFF_FFFF;
`endif
        return r;
    endfunction

    // compare process: every cycle the bench is out of reset
    always @(negedge clk) begin
        if (chk_en) begin
            check("d_stall", 32'(d_stall), 32'(exp_stall));
            check("req", 32'(mem_if.req), 32'(exp_req));
            check("state", 32'(state), 32'(exp_state));
            check("readdataM", readdataM, exp_rdata);
            if (mem_if.req) begin
                check("addr", mem_if.addr, exp_addr);
                check("size", 32'(mem_if.size), 32'(exp_size));
                check("wr", 32'(mem_if.wr), 32'(exp_wr));
                check("wdata", mem_if.wdata, exp_wdata);
                obs_addr = mem_if.addr;
                obs_size = mem_if.size;
                obs_wr   = mem_if.wr;
            end
            if (mem_if.req && !prev_req) req_pulses++;
            prev_req = mem_if.req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rd_pending) begin
            exp_rdata  = rd_val_q;
            rd_pending = 1'b0;
        end
    endtask

    task automatic idle_cycle(input logic exc_en);
        data_sram_en   = exc_en;
        hasException   = exc_en;
        memwriteEN     = 4'($urandom_range(0, 15));
        aluoutM        = $urandom;
        longest_stall  = 1'($urandom_range(0, 1));
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'($urandom_range(0, 1));
        mem_if.rdata   = $urandom;
        exp_state = S_IDLE;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        step();
    endtask

    // one access: addr_ok after a_dly extra req cycles, data_ok d_dly cycles after
    // acceptance (0 = same cycle), then frz frozen cycles in DONE
    task automatic do_txn(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd_val, input int a_dly, input int d_dly,
                          input int frz, input logic exc_mid);
        data_sram_en   = 1'b1;
        memwriteEN     = strb;
        aluoutM        = a;
        writedataM     = wd;
        hasException   = 1'b0;
        longest_stall  = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'($urandom_range(0, 1));
        mem_if.rdata   = $urandom;
        exp_addr  = model_addr(strb, a);
        exp_size  = model_size(strb);
        exp_wr    = (strb != 4'b0000);
        exp_wdata = wd;
        exp_state = S_IDLE;
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        step();
        for (int i = 0; i <= a_dly; i++) begin
            exp_state      = S_ADDR;
            exp_stall      = 1'b1;
            exp_req        = 1'b1;
            hasException   = exc_mid;
            longest_stall  = 1'($urandom_range(0, 1));
            mem_if.addr_ok = (i == a_dly);
            mem_if.data_ok = (i == a_dly) ? (d_dly == 0) : 1'($urandom_range(0, 1));
            mem_if.rdata   = (i == a_dly && d_dly == 0) ? rd_val : $urandom;
            if (i == a_dly && d_dly == 0 && strb == 4'b0000) begin
                rd_pending = 1'b1;
                rd_val_q   = rd_val;
            end
            step();
        end
        for (int j = 1; j <= d_dly; j++) begin
            exp_state      = S_DATA;
            exp_stall      = 1'b1;
            exp_req        = 1'b0;
            hasException   = exc_mid;
            longest_stall  = 1'($urandom_range(0, 1));
            mem_if.addr_ok = 1'b0;
            mem_if.data_ok = (j == d_dly);
            mem_if.rdata   = (j == d_dly) ? rd_val : $urandom;
            if (j == d_dly && strb == 4'b0000) begin
                rd_pending = 1'b1;
                rd_val_q   = rd_val;
            end
            step();
        end
        for (int k = 0; k <= frz; k++) begin
            exp_state      = S_DONE;
            exp_stall      = 1'b0;
            exp_req        = 1'b0;
            hasException   = 1'b0;
            longest_stall  = (k < frz);
            data_sram_en   = (k < frz);
            mem_if.addr_ok = 1'b0;
            mem_if.data_ok = 1'($urandom_range(0, 1));
            mem_if.rdata   = $urandom;
            step();
        end
        data_sram_en   = 1'b0;
        mem_if.data_ok = 1'b0;
        exp_state = S_IDLE;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
    endtask

    logic [3:0] strb_tbl [8];

    initial begin
        strb_tbl[0] = 4'b0000; strb_tbl[1] = 4'b0001; strb_tbl[2] = 4'b1000;
        strb_tbl[3] = 4'b0011; strb_tbl[4] = 4'b1100; strb_tbl[5] = 4'b1111;
        strb_tbl[6] = 4'b0110; strb_tbl[7] = 4'b0111;

        rst = 1'b1;
        data_sram_en = 1'b0; memwriteEN = 4'b0; aluoutM = 32'd0; writedataM = 32'd0;
        hasException = 1'b0; longest_stall = 1'b0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'd0;
        exp_rdata = 32'd0; exp_state = S_IDLE; exp_stall = 1'b0; exp_req = 1'b0;
        step();
        step();
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_req", 32'(mem_if.req), 32'd0);
        check("rst_wr", 32'(mem_if.wr), 32'd0);
        check("rst_size", 32'(mem_if.size), 32'd0);
        check("rst_addr", mem_if.addr, 32'd0);
        check("rst_wdata", mem_if.wdata, 32'd0);
        check("rst_readdataM", readdataM, 32'd0);
        check("rst_d_stall", 32'(d_stall), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycle(1'b0);

        // aligned read, both handshakes on the first req cycle
        do_txn(4'b0000, 32'h8000_1003, 32'h5555_AAAA, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
`ifdef DBRIDGE_ADDR_MAP_EN
        check("read_addr_lit", obs_addr, 32'h0000_1000);
`else
        check("read_addr_lit", obs_addr, 32'h8000_1000);
`endif
        check("read_size_lit", 32'(obs_size), 32'd2);
        check("read_wr_lit", 32'(obs_wr), 32'd0);
        check("read_data_lit", readdataM, 32'hDEAD_BEEF);
        idle_cycle(1'b0);

        // byte store with late addr_ok and data_ok; readdataM must not move
        do_txn(4'b0100, 32'hBFC0_0002, 32'h00AB_0000, 32'h1111_2222, 3, 2, 0, 1'b0);
`ifdef DBRIDGE_ADDR_MAP_EN
        check("bstore_addr_lit", obs_addr, 32'h1FC0_0002);
`else
        check("bstore_addr_lit", obs_addr, 32'hBFC0_0002);
`endif
        check("bstore_size_lit", 32'(obs_size), 32'd0);
        check("bstore_wr_lit", 32'(obs_wr), 32'd1);
        check("bstore_keep_rdata", readdataM, 32'hDEAD_BEEF);

        // read completing under a four-cycle freeze
        req_pulses = 0;
        do_txn(4'b0000, 32'h0000_0040, 32'd0, 32'hCAFE_0001, 1, 1, 4, 1'b0);
        check("freeze_req_pulses", 32'(req_pulses), 32'd1);

        // exception in IDLE: no request, no stall
        req_pulses = 0;
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        check("exc_no_req", 32'(req_pulses), 32'd0);

        // exception raised mid-transaction does not abort it
        do_txn(4'b0000, 32'h0000_0100, 32'd0, 32'h1234_5678, 0, 2, 0, 1'b1);
        check("exc_mid_rdata", readdataM, 32'h1234_5678);

        // halfword store
        do_txn(4'b1100, 32'hA000_0000, 32'hBEEF_0000, 32'd0, 0, 1, 0, 1'b0);
        check("half_size_lit", 32'(obs_size), 32'd1);
`ifdef DBRIDGE_ADDR_MAP_EN
        check("half_addr_lit", obs_addr, 32'h0000_0000);
`else
        check("half_addr_lit", obs_addr, 32'hA000_0000);
`endif

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 2) == 0) ? 4'b0000 : strb_tbl[$urandom_range(0, 7)];
            do_txn(s, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle(1'($urandom_range(0, 1)));
        end

        // reset while waiting in DATA, then a stray data_ok
        do_txn(4'b0000, 32'h0000_0200, 32'd0, 32'h7777_8888, 0, 0, 0, 1'b0);
        data_sram_en = 1'b1; memwriteEN = 4'b0000; aluoutM = 32'h0000_0300; hasException = 1'b0;
        longest_stall = 1'b0; mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0;
        exp_addr = model_addr(4'b0000, 32'h0000_0300); exp_size = 2'd2; exp_wr = 1'b0;
        exp_wdata = writedataM; exp_state = S_IDLE; exp_stall = 1'b1; exp_req = 1'b0;
        step();
        mem_if.addr_ok = 1'b1; exp_state = S_ADDR; exp_req = 1'b1;
        step();
        mem_if.addr_ok = 1'b0; exp_state = S_DATA; exp_req = 1'b0;
        #6;
        chk_en = 1'b0;
        rst = 1'b1;
        data_sram_en = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'(S_IDLE));
        check("mid_rst_readdataM", readdataM, 32'd0);
        check("mid_rst_addr", mem_if.addr, 32'd0);
        check("mid_rst_req", 32'(mem_if.req), 32'd0);
        exp_rdata = 32'd0;
        step();
        rst = 1'b0;
        exp_state = S_IDLE; exp_stall = 1'b0; exp_req = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hBAD0_BAD0;
        chk_en = 1'b1;
        step();
        mem_if.data_ok = 1'b0;
        step();
        check("stray_state", 32'(state), 32'(S_IDLE));
        check("stray_readdataM", readdataM, 32'd0);

        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_sramlike_bridge.md
D_SRAMLIKE_BRIDGE -- requirements
Module: d_sramlike_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have core-side inputs: data_sram_en 1 (M-stage access), memwriteEN 4 (byte strobes, 0 = read), aluoutM 32 (address), writedataM 32 (byte-lane aligned), hasException 1 (M-stage exception), longest_stall 1 (global pipeline freeze).
REQ-004 SHALL have core-side outputs: readdataM 32 (load word), d_stall 1 (hold pipeline).
REQ-005 SHALL have memory-side outputs: req 1, wr 1, size 2, addr 32, wdata 32.
REQ-006 SHALL have memory-side inputs: addr_ok 1 (request accepted), data_ok 1 (transfer complete), rdata 32.

Function
REQ-007 SHALL implement FSM IDLE, ADDR, DATA, DONE.
REQ-008 SHALL, in IDLE with data_sram_en=1 and hasException=0, latch wr, size, addr and wdata, then enter ADDR next cycle.
REQ-009 SHALL, in IDLE with hasException=1, issue no request and keep d_stall=0.
REQ-010 SHALL assert req only in ADDR; payload stays constant until addr_ok.
REQ-011 SHALL go ADDR->DATA on req&addr_ok; SHALL go DATA->DONE on data_ok.
REQ-012 SHALL accept addr_ok and data_ok in the same cycle in ADDR and go directly to DONE.
REQ-013 SHALL ignore data_ok outside DATA and outside ADDR&addr_ok.
REQ-014 SHALL capture rdata into readdataM on the completing data_ok of a read; readdataM holds until the next completed read; writes do not change it.
REQ-015 SHALL drive d_stall = (IDLE & data_sram_en & ~hasException) | ADDR | DATA; it is 0 in DONE.
REQ-016 SHALL stay in DONE while longest_stall=1, so an instruction frozen in M is never re-issued; SHALL go DONE->IDLE when longest_stall=0.
REQ-017 SHALL derive size: read -> 2 with addr[1:0] forced to 00; write strobe 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 -> 2; any other write strobe -> 2.
REQ-018 SHALL set wr=1 iff memwriteEN!=0 and pass writedataM unchanged to wdata.
REQ-019 SHALL complete the in-flight transaction (no abort) when hasException rises in ADDR or DATA.
REQ-020 SHALL produce at least 3 cycles from request in IDLE to d_stall low (IDLE, ADDR, DONE) when addr_ok and data_ok arrive together.

Reset
REQ-021 SHALL on rst enter IDLE with req=0, wr=0, size=0, addr=0, wdata=0 and readdataM=0; d_stall then follows REQ-015.
REQ-022 SHALL on rst mid-transaction abandon it and ignore any later data_ok until a new request.

Configuration
REQ-023 With DBRIDGE_ADDR_MAP_EN defined, SHALL map 0x8000_0000-0xBFFF_FFFF to physical by clearing addr[31:29] and pass other addresses unchanged; without it, SHALL pass addr unchanged.

Structure
REQ-024 SHALL take the FSM state encoding and the size constants (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2) from shared package sramlike_pkg.
REQ-025 SHALL implement strobe-to-size decode (REQ-017) in combinational sub-module strb2size.

Verification
REQ-026 Read: en=1, strobe=0, aluoutM=0x8000_1003, addr_ok=data_ok=1 on first req cycle -> addr=0x0000_1000 (map on), size=2, wr=0; readdataM=rdata=0xDEAD_BEEF; d_stall high 2 cycles.
REQ-027 Byte store: strobe=0100, aluoutM=0xBFC0_0002, addr_ok 3 cycles late, data_ok 2 cycles after -> size=0, wr=1, addr=0x1FC0_0002; req held and payload stable throughout; d_stall low only in DONE.
REQ-028 Freeze: read completes while longest_stall=1 for 4 cycles -> exactly one req pulse; state DONE for 4 cycles, then IDLE.
REQ-029 Exception: en=1, hasException=1 -> req never asserted, d_stall=0; exception raised in DATA -> transaction completes normally.
REQ-030 Reset in DATA, then stray data_ok -> IDLE, readdataM=0, no state change from the stray data_ok.
REQ-031 Halfword store strobe 1100 -> size=1; macro undefined with aluoutM=0xA000_0000 -> addr=0xA000_0000.
